bl_order_seq: RTL and testbench
===============================

# bl_order_seq

Parametrised baseline-order sequencer for the X-engine output stream. It tracks `vld_out`/`sync_out` from `xeng_top` and, for every valid output word, emits the antenna pair, tap index and flags for that word: conjugation, autocorrelation, redundant half-tap, and first/last of window. It replaces the fixed-size order generator with one that handles any `N_ANTS`, tolerates gaps in `en`, timestamps windows with `mcnt`, and flags syncs that arrive mid-window. It drives bench checkers and downstream packetisers.

## Interface
- `N_ANTS`, 32: dual-pol antenna count, ≥2; power of two not required.
- `MCNT_WIDTH`, 48: timestamp width.
- `FRAME_BITS`, 16: width of the window counter.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `sync`  in  1  window-restart pulse (from `sync_out`).
- `en`  in  1  one output word present this cycle (from `vld_out`).
- `mcnt_in`  in  MCNT_WIDTH  timestamp of the current word (from `mcnt_out`).
- `vld`  out  1  outputs below describe a word.
- `ant_a`, `ant_b`  out  ANT_BITS  canonical pair, `ant_a >= ant_b`; ANT_BITS = clog2(N_ANTS), minimum 1.
- `tap`  out  clog2(N_TAPS)  tap index, N_TAPS = N_ANTS/2+1 (floor).
- `conj`  out  1  word holds the conjugate of (ant_a, ant_b).
- `auto`  out  1  tap 0.
- `redundant`  out  1  duplicate baseline in the last half-tap.
- `first`, `last`  out  1  first/last word of a window.
- `mcnt_out`  out  MCNT_WIDTH  `mcnt_in` latched at the window's first word.
- `frame_cnt`  out  FRAME_BITS  completed windows since reset; wraps.
- `sync_err`  out  1  one-cycle pulse: sync arrived mid-window.

## Operation
- Window length L = N_ANTS·N_TAPS words. Index k = t·N_ANTS + i, with t the tap and i the antenna, i fastest.
- Raw pair: a = i, b = (i − t) mod N_ANTS. If a < b, swap them and set `conj`=1; otherwise `conj`=0.
- `auto` = (t==0). `redundant` = (N_ANTS even) & (t==N_ANTS/2) & (i ≥ N_ANTS/2).
- The counters advance only when `en`=1. The (i,t) counters wrap to (0,0) after (N_ANTS−1, N_TAPS−1). On that wrap, `frame_cnt` increments.
- `sync` restarts the window: the next `en` word is k=0.
  - `sync`&`en` in the same cycle: that word is k=0.
  - If `sync` arrives while k≠0, pulse `sync_err`, discard the partial window, and leave `frame_cnt` unchanged.
- Before the first `sync` after reset, `en` is ignored and `vld` stays 0.
- `mcnt_out` updates only on k=0 words and holds for the rest of the window.
- Counters use mod arithmetic with no wide division; b is computed as i−t with a conditional +N_ANTS.

## Timing
- All outputs are registered. Latency from an `en` word to its `vld` is 1 cycle. `sync_err` appears 1 cycle after `sync`.
- Reset values: every output is 0; the armed flag is cleared and k=0.
- `rst` mid-window: next cycle all outputs are 0 and the block is disarmed. It waits for `sync`.
- `vld`=0 when `en`=0; the other outputs hold their last value.
- Throughput: one word per cycle when `en` is continuous, with no bubble at the window wrap.

## Structure
- Shared package `xeng_pkg`: `clog2` function, `N_TAPS` and `ANT_BITS` derivations, and a packed `bl_info_t` struct {ant_a, ant_b, tap, conj, auto, redundant, first, last}. Reused by the packetiser and by checkers.
- Sub-module `mod_counter` (parametrised modulus, `en`, `clr`, `wrap` out), instantiated twice: once for i, once for t.
- The rest is the pair/swap logic and the output register stage.

## Test plan
- N_ANTS=4, `sync` then 12 continuous `en` → pairs (0,0),(1,1),(2,2),(3,3),(3,0)c,(1,0),(2,1),(3,2),(2,0)c,(3,1)c,(2,0)r,(3,1)r (c = `conj`, r = `redundant`). `first` on word 0, `last` on word 11, `frame_cnt` 0→1.
- Same stimulus with `en` toggling 1,0,1,0 → identical word sequence; `vld` shows gaps.
- `sync` at k=5 → `sync_err` pulse; the next word is (0,0) with `first`=1; `frame_cnt` unchanged.
- `mcnt_in`=0x100 on word 0, then it increments → `mcnt_out`=0x100 for all 12 words.
- N_ANTS=5 (N_TAPS=3, L=15) → no `redundant`; last word (4,2)-derived is (4,2), `conj`=0.
- `rst` at word 7, then `en` without `sync` → `vld` stays 0; after `sync`, the sequence restarts at (0,0).

Source files
------------

// File: rtl/xeng_pkg.sv
// Shared X-engine output-order types and width helpers.
// Used by the order sequencer, the packetiser and the bench checkers.
package xeng_pkg;

  // Baseline info sized for the largest supported array; narrower users zero-extend.
  localparam int BL_ANT_W_MAX = 12;
  localparam int BL_TAP_W_MAX = 12;

  typedef enum logic {
    SEQ_IDLE  = 1'b0,
    SEQ_ARMED = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [BL_ANT_W_MAX-1:0] ant_a;
    logic [BL_ANT_W_MAX-1:0] ant_b;
    logic [BL_TAP_W_MAX-1:0] tap;
    logic                    conj;
    logic                    auto;
    logic                    redundant;
    logic                    first;
    logic                    last;
  } bl_info_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic int n_taps(input int n_ants);
    return n_ants / 2 + 1;
  endfunction

  function automatic int ant_bits(input int n_ants);
    return (clog2(n_ants) < 1) ? 1 : clog2(n_ants);
  endfunction

  function automatic int tap_bits(input int n_ants);
    return (clog2(n_taps(n_ants)) < 1) ? 1 : clog2(n_taps(n_ants));
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with restart. cnt_o is the index of the word in the
// current cycle (zero while clr_i is high), wrap_o flags its terminal value.
module mod_counter #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o  = clr_i ? '0 : cnt_q;
  assign wrap_o = (cnt_o == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i)       cnt_d = wrap_o ? '0 : cnt_o + 1'b1;
    else if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bl_order_seq.sv
// Baseline-order sequencer: labels each valid X-engine output word with its
// canonical antenna pair, tap, flags, window timestamp and window count.
//
// state     | meaning
// SEQ_IDLE  | after reset; en ignored until the first sync
// SEQ_ARMED | tracking windows; every en word is labelled
module bl_order_seq
  import xeng_pkg::*;
#(
  parameter int  N_ANTS     = 32,
  parameter int  MCNT_WIDTH = 48,
  parameter int  FRAME_BITS = 16,
  localparam int ANT_BITS   = ant_bits(N_ANTS),
  localparam int TAP_BITS   = tap_bits(N_ANTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sync_i,
  input  logic                  en_i,
  input  logic [MCNT_WIDTH-1:0] mcnt_i,
  output logic                  vld_o,
  output logic [ANT_BITS-1:0]   ant_a_o,
  output logic [ANT_BITS-1:0]   ant_b_o,
  output logic [TAP_BITS-1:0]   tap_o,
  output logic                  conj_o,
  output logic                  auto_o,
  output logic                  redundant_o,
  output logic                  first_o,
  output logic                  last_o,
  output logic [MCNT_WIDTH-1:0] mcnt_o,
  output logic [FRAME_BITS-1:0] frame_cnt_o,
  output logic                  sync_err_o
);

  localparam int                  N_TAPS = n_taps(N_ANTS);
  localparam logic [ANT_BITS-1:0] N_A    = ANT_BITS'(N_ANTS);
  localparam logic [ANT_BITS-1:0] HALF_A = ANT_BITS'(N_ANTS / 2);
  localparam logic [TAP_BITS-1:0] HALF_T = TAP_BITS'(N_ANTS / 2);
  localparam logic                EVEN   = ((N_ANTS % 2) == 0);

  seq_state_e state_q;
  logic adv, i_wrap, t_wrap, k0, wrap_k;
  logic k_nz_q, k_nz_d;
  logic [ANT_BITS-1:0] i_cur, t_a, b_raw, ant_a_d, ant_b_d;
  logic [TAP_BITS-1:0] t_cur;
  logic conj_d, red_d;

  logic                  vld_q, conj_q, auto_q, red_q, first_q, last_q, sync_err_q;
  logic [ANT_BITS-1:0]   ant_a_q, ant_b_q;
  logic [TAP_BITS-1:0]   tap_q;
  logic [MCNT_WIDTH-1:0] mcnt_q;
  logic [FRAME_BITS-1:0] frame_q;

  // A sync in the same cycle as en both arms the block and makes that word k=0.
  assign adv = en_i & (sync_i | (state_q == SEQ_ARMED));

  mod_counter #(.MOD(N_ANTS), .W(ANT_BITS)) u_cnt_i (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (adv),
    .clr_i  (sync_i),
    .cnt_o  (i_cur),
    .wrap_o (i_wrap)
  );

  mod_counter #(.MOD(N_TAPS), .W(TAP_BITS)) u_cnt_t (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (adv & i_wrap),
    .clr_i  (sync_i),
    .cnt_o  (t_cur),
    .wrap_o (t_wrap)
  );

  always_comb begin
    t_a     = ANT_BITS'(t_cur);
    // Result is < N_ANTS, so ANT_BITS-wide modular arithmetic is exact.
    b_raw   = (i_cur < t_a) ? (i_cur - t_a + N_A) : (i_cur - t_a);
    conj_d  = (i_cur < b_raw);
    ant_a_d = conj_d ? b_raw : i_cur;
    ant_b_d = conj_d ? i_cur : b_raw;
    red_d   = EVEN & (t_cur == HALF_T) & (i_cur >= HALF_A);
    k0      = (i_cur == '0) & (t_cur == '0);
    wrap_k  = i_wrap & t_wrap;
    k_nz_d  = k_nz_q;
    if (adv)         k_nz_d = ~wrap_k;
    else if (sync_i) k_nz_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SEQ_IDLE;
      k_nz_q     <= 1'b0;
      vld_q      <= 1'b0;
      ant_a_q    <= '0;
      ant_b_q    <= '0;
      tap_q      <= '0;
      conj_q     <= 1'b0;
      auto_q     <= 1'b0;
      red_q      <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      mcnt_q     <= '0;
      frame_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      if (sync_i) state_q <= SEQ_ARMED;
      k_nz_q     <= k_nz_d;
      sync_err_q <= sync_i & k_nz_q;
      vld_q      <= adv;
      if (adv) begin
        ant_a_q <= ant_a_d;
        ant_b_q <= ant_b_d;
        tap_q   <= t_cur;
        conj_q  <= conj_d;
        auto_q  <= (t_cur == '0);
        red_q   <= red_d;
        first_q <= k0;
        last_q  <= wrap_k;
        if (k0)     mcnt_q  <= mcnt_i;
        if (wrap_k) frame_q <= frame_q + 1'b1;
      end
    end
  end

  assign vld_o       = vld_q;
  assign ant_a_o     = ant_a_q;
  assign ant_b_o     = ant_b_q;
  assign tap_o       = tap_q;
  assign conj_o      = conj_q;
  assign auto_o      = auto_q;
  assign redundant_o = red_q;
  assign first_o     = first_q;
  assign last_o      = last_q;
  assign mcnt_o      = mcnt_q;
  assign frame_cnt_o = frame_q;
  assign sync_err_o  = sync_err_q;

endmodule

// File: tb/tb_bl_order_seq.sv
// Directed bench for bl_order_seq: a 4-antenna instance for ordering, gaps,
// mid-window sync and reset, and a 5-antenna instance for the odd case.
module tb_bl_order_seq;

  logic clk;
  int checks = 0;
  int errors = 0;

  logic        rst4, sync4, en4;
  logic [47:0] mcnt4, mcnt_o4;
  logic        vld4, conj4, auto4, red4, first4, last4, serr4;
  logic [1:0]  a4, b4, tap4;
  logic [15:0] frame4;

  logic        rst5, sync5, en5;
  logic [47:0] mcnt5, mcnt_o5;
  logic        vld5, conj5, auto5, red5, first5, last5, serr5;
  logic [2:0]  a5, b5;
  logic [1:0]  tap5;
  logic [15:0] frame5;

  logic [10:0] obs4;
  assign obs4 = {a4, b4, tap4, conj4, auto4, red4, first4, last4};

  bl_order_seq #(.N_ANTS(4), .MCNT_WIDTH(48), .FRAME_BITS(16)) dut4 (
    .clk_i(clk), .rst_i(rst4), .sync_i(sync4), .en_i(en4), .mcnt_i(mcnt4),
    .vld_o(vld4), .ant_a_o(a4), .ant_b_o(b4), .tap_o(tap4), .conj_o(conj4),
    .auto_o(auto4), .redundant_o(red4), .first_o(first4), .last_o(last4),
    .mcnt_o(mcnt_o4), .frame_cnt_o(frame4), .sync_err_o(serr4)
  );

  bl_order_seq #(.N_ANTS(5), .MCNT_WIDTH(48), .FRAME_BITS(16)) dut5 (
    .clk_i(clk), .rst_i(rst5), .sync_i(sync5), .en_i(en5), .mcnt_i(mcnt5),
    .vld_o(vld5), .ant_a_o(a5), .ant_b_o(b5), .tap_o(tap5), .conj_o(conj5),
    .auto_o(auto5), .redundant_o(red5), .first_o(first5), .last_o(last5),
    .mcnt_o(mcnt_o5), .frame_cnt_o(frame5), .sync_err_o(serr5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-derived order for N_ANTS=4: pairs, conj on words 4,8,9, redundant on 10,11.
  int ea [12] = '{0, 1, 2, 3, 3, 1, 2, 3, 2, 3, 2, 3};
  int eb [12] = '{0, 1, 2, 3, 0, 0, 1, 2, 0, 1, 0, 1};

  function automatic logic [10:0] exp4(input int k);
    logic [1:0] a, b, t;
    a = 2'(ea[k]);
    b = 2'(eb[k]);
    t = 2'(k / 4);
    return {a, b, t, (k == 4 || k == 8 || k == 9), (k < 4), (k >= 10), (k == 0), (k == 11)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; en4 = 1'b1; sync4 = 1'b0;
    tick(); tick();
    checks++;
    if ({vld4, obs4, frame4, mcnt_o4, serr4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got vld=%b word=%h frame=%0d mcnt=%h err=%b exp all 0",
               vld4, obs4, frame4, mcnt_o4, serr4);
    end
    rst4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (vld4 !== 1'b0) begin
        errors++;
        $display("FAIL unarmed_vld cycle=%0d got %b exp 0", c, vld4);
      end
    end
    en4 = 1'b0;
  endtask

  task automatic test_continuous();
    sync4 = 1'b1; en4 = 1'b0; mcnt4 = 48'h0;
    tick();
    checks++;
    if (vld4 !== 1'b0 || serr4 !== 1'b0) begin
      errors++;
      $display("FAIL cont_sync_only got vld=%b err=%b exp 0 0", vld4, serr4);
    end
    sync4 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      en4 = 1'b1; mcnt4 = 48'h100 + 48'(k);
      tick();
      checks++;
      if (vld4 !== 1'b1 || obs4 !== exp4(k)) begin
        errors++;
        $display("FAIL cont_word k=%0d got vld=%b word=%h exp vld=1 word=%h", k, vld4, obs4, exp4(k));
      end
      checks++;
      if (frame4 !== 16'((k == 11) ? 1 : 0)) begin
        errors++;
        $display("FAIL cont_frame k=%0d got %0d exp %0d", k, frame4, (k == 11) ? 1 : 0);
      end
      checks++;
      if (mcnt_o4 !== 48'h100) begin
        errors++;
        $display("FAIL cont_mcnt k=%0d got %h exp 100", k, mcnt_o4);
      end
    end
    en4 = 1'b0;
    tick();
    checks++;
    if (vld4 !== 1'b0 || obs4 !== exp4(11) || frame4 !== 16'd1) begin
      errors++;
      $display("FAIL cont_hold got vld=%b word=%h frame=%0d exp vld=0 word=%h frame=1",
               vld4, obs4, frame4, exp4(11));
    end
  endtask

  task automatic test_gaps();
    for (int c = 0; c < 24; c++) begin
      sync4 = (c == 0); en4 = ((c % 2) == 0); mcnt4 = 48'h200 + 48'(c);
      tick();
      checks++;
      if (vld4 !== en4 || obs4 !== exp4(c / 2)) begin
        errors++;
        $display("FAIL gap_word cycle=%0d got vld=%b word=%h exp vld=%b word=%h",
                 c, vld4, obs4, en4, exp4(c / 2));
      end
      checks++;
      if (frame4 !== 16'((c >= 22) ? 2 : 1) || mcnt_o4 !== 48'h200) begin
        errors++;
        $display("FAIL gap_frame cycle=%0d got frame=%0d mcnt=%h exp frame=%0d mcnt=200",
                 c, frame4, mcnt_o4, (c >= 22) ? 2 : 1);
      end
    end
    sync4 = 1'b0; en4 = 1'b0;
  endtask

  task automatic test_sync_mid();
    for (int k = 0; k < 5; k++) begin
      sync4 = (k == 0); en4 = 1'b1;
      tick();
      checks++;
      if (obs4 !== exp4(k) || serr4 !== 1'b0) begin
        errors++;
        $display("FAIL mid_pre k=%0d got word=%h err=%b exp word=%h err=0", k, obs4, serr4, exp4(k));
      end
    end
    sync4 = 1'b1; en4 = 1'b0;
    tick();
    checks++;
    if (serr4 !== 1'b1 || vld4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_err got err=%b vld=%b exp err=1 vld=0", serr4, vld4);
    end
    sync4 = 1'b0; en4 = 1'b1;
    tick();
    checks++;
    if (serr4 !== 1'b0 || vld4 !== 1'b1 || obs4 !== exp4(0) || frame4 !== 16'd2) begin
      errors++;
      $display("FAIL mid_restart got err=%b vld=%b word=%h frame=%0d exp err=0 vld=1 word=%h frame=2",
               serr4, vld4, obs4, frame4, exp4(0));
    end
    for (int k = 1; k < 12; k++) begin
      tick();
      checks++;
      if (obs4 !== exp4(k) || frame4 !== 16'((k == 11) ? 3 : 2)) begin
        errors++;
        $display("FAIL mid_rest k=%0d got word=%h frame=%0d exp word=%h frame=%0d",
                 k, obs4, frame4, exp4(k), (k == 11) ? 3 : 2);
      end
    end
    en4 = 1'b0;
  endtask

  task automatic test_rst_mid();
    sync4 = 1'b1; en4 = 1'b0;
    tick();
    sync4 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      en4 = 1'b1; mcnt4 = 48'h250 + 48'(k);
      tick();
    end
    checks++;
    if (obs4 !== exp4(6)) begin
      errors++;
      $display("FAIL rst_pre got %h exp %h", obs4, exp4(6));
    end
    rst4 = 1'b1;
    tick();
    checks++;
    if ({vld4, obs4, frame4, mcnt_o4, serr4} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got vld=%b word=%h frame=%0d mcnt=%h err=%b exp all 0",
               vld4, obs4, frame4, mcnt_o4, serr4);
    end
    rst4 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (vld4 !== 1'b0) begin
        errors++;
        $display("FAIL rst_disarmed cycle=%0d got vld=%b exp 0", c, vld4);
      end
    end
    sync4 = 1'b1; mcnt4 = 48'h300;
    tick();
    checks++;
    if (vld4 !== 1'b1 || obs4 !== exp4(0) || mcnt_o4 !== 48'h300 || frame4 !== 16'd0) begin
      errors++;
      $display("FAIL rst_restart got vld=%b word=%h mcnt=%h frame=%0d exp vld=1 word=%h mcnt=300 frame=0",
               vld4, obs4, mcnt_o4, frame4, exp4(0));
    end
    sync4 = 1'b0; mcnt4 = 48'h301;
    tick();
    checks++;
    if (obs4 !== exp4(1) || mcnt_o4 !== 48'h300) begin
      errors++;
      $display("FAIL rst_second got word=%h mcnt=%h exp word=%h mcnt=300", obs4, mcnt_o4, exp4(1));
    end
    en4 = 1'b0;
  endtask

  task automatic test_n5();
    rst5 = 1'b1;
    tick();
    rst5 = 1'b0; sync5 = 1'b1;
    tick();
    sync5 = 1'b0;
    for (int k = 0; k < 15; k++) begin
      en5 = 1'b1; mcnt5 = 48'h500 + 48'(k);
      tick();
      checks++;
      if (vld5 !== 1'b1 || red5 !== 1'b0) begin
        errors++;
        $display("FAIL n5_vld_red k=%0d got vld=%b red=%b exp 1 0", k, vld5, red5);
      end
      if (k == 0) begin
        checks++;
        if ({a5, b5, tap5, conj5, auto5, first5, last5} !== {3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL n5_first got a=%0d b=%0d tap=%0d c=%b au=%b f=%b l=%b exp 0 0 0 0 1 1 0",
                   a5, b5, tap5, conj5, auto5, first5, last5);
        end
      end
      if (k == 5) begin
        checks++;
        if ({a5, b5, tap5, conj5} !== {3'd4, 3'd0, 2'd1, 1'b1}) begin
          errors++;
          $display("FAIL n5_k5 got a=%0d b=%0d tap=%0d c=%b exp 4 0 1 1", a5, b5, tap5, conj5);
        end
      end
      if (k == 14) begin
        checks++;
        if ({a5, b5, tap5, conj5, last5, frame5, mcnt_o5} !==
            {3'd4, 3'd2, 2'd2, 1'b0, 1'b1, 16'd1, 48'h500}) begin
          errors++;
          $display("FAIL n5_last got a=%0d b=%0d tap=%0d c=%b l=%b frame=%0d mcnt=%h exp 4 2 2 0 1 1 500",
                   a5, b5, tap5, conj5, last5, frame5, mcnt_o5);
        end
      end
    end
    en5 = 1'b0;
  endtask

  initial begin
    rst4 = 1'b1; sync4 = 1'b0; en4 = 1'b0; mcnt4 = '0;
    rst5 = 1'b1; sync5 = 1'b0; en5 = 1'b0; mcnt5 = '0;
    test_reset();
    test_continuous();
    test_gaps();
    test_sync_mid();
    test_rst_mid();
    test_n5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
